inv_sub_bytes_iter: RTL and testbench

//  Iterative AES InvSubBytes engine for the decryption datapath; inverse of the forward S-box stage.

---
 rtl/inv_sub_bytes_iter.sv | 170 +++++++++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine: loads a 128-bit state and substitutes
// BYTES_PER_CYCLE bytes per clock through the inverse S-box, low bytes first.
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4   // legal: 1, 2, 4, 8, 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int LANE_W    = 8 * BYTES_PER_CYCLE;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       data_q, data_d;
    logic [LANE_W-1:0]  lane_in, lane_out;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        case (b)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5;
            8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e;
            8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82;
            8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44;
            8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32;
            8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b;
            8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66;
            8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49;
            8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64;
            8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc;
            8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50;
            8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57;
            8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00;
            8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05;
            8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f;
            8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03;
            8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41;
            8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce;
            8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22;
            8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8;
            8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71;
            8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e;
            8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b;
            8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe;
            8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33;
            8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59;
            8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9;
            8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f;
            8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d;
            8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c;
            8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e;
            8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63;
            8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Constant-index mux keeps the byte-window select free of runtime arithmetic.
    always_comb begin
        lane_in = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                lane_in = data_q[i*LANE_W +: LANE_W];
            end
        end
    end

    for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
        assign lane_out[gi*8 +: 8] = inv_sbox(lane_in[gi*8 +: 8]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NUM_STEPS; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        data_d[i*LANE_W +: LANE_W] = lane_out;
                    end
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: three instances (4, 1 and 16 bytes/cycle) checked
// against an inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] iv;
    logic [2:0] ordy;
    logic [2:0][127:0] di;

    logic ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [127:0] dq0, dq1, dq2;
    wire  [2:0] ir = {ir2, ir1, ir0};
    wire  [2:0] ov = {ov2, ov1, ov0};
    wire  [2:0] bz = {bz2, bz1, bz0};
    logic [127:0] dq [3];
    assign dq[0] = dq0;
    assign dq[1] = dq1;
    assign dq[2] = dq2;

    int lat_exp [3] = '{4, 16, 1};
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .data_in(di[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .data_out(dq0), .busy(bz0));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .data_in(di[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .data_out(dq1), .busy(bz1));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .data_in(di[2]),
        .out_valid(ov2), .out_ready(ordy[2]), .data_out(dq2), .busy(bz2));

    // Reference: S-box = affine(multiplicative inverse in GF(2^8)); inverse table by inversion.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] y = 8'h01;
        if (x == 8'h00) y = 8'h00;
        else for (int i = 0; i < 254; i++) y = gf_mul(y, x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Handshake one state into instance idx and wait (bounded) for out_valid; no checks here.
    task automatic do_start(input int idx, input logic [127:0] din, output int lat, output bit busy_ok);
        int wt = 0;
        @(negedge clk);
        iv[idx] = 1'b1; di[idx] = din; ordy[idx] = 1'b0;
        while (!ir[idx] && wt < 50) begin @(negedge clk); wt++; end
        @(posedge clk);
        @(negedge clk);
        iv[idx] = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (!ov[idx] && lat < 100) begin
            if (!bz[idx]) busy_ok = 1'b0;
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    task automatic do_consume(input int idx, input logic [127:0] din);
        $display("txn inst=%0d in=%h out=%h", idx, din, dq[idx]);
        ordy[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid inst=%0d got=%b exp=0", k, ov[k]); end
            n_checks++; if (bz[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy inst=%0d got=%b exp=0", k, bz[k]); end
            n_checks++; if (ir[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready inst=%0d got=%b exp=1", k, ir[k]); end
            n_checks++; if (dq[k] !== 128'h0) begin n_fail++; $display("FAIL reset_data_out inst=%0d got=%h exp=0", k, dq[k]); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_vector();
        logic [127:0] din = 128'hd42711aee0bf98f1b8b45de51e415230;
        int lat; bit bok;
        do_start(0, din, lat, bok);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL known_latency got=%0d exp=4", lat); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL known_busy got=0 exp=1"); end
        n_checks++; if (dq[0] !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
            n_fail++; $display("FAIL known_vector got=%h exp=193de3bea0f4e22b9ac68d2ae9f84808", dq[0]); end
        n_checks++; if (dq[0] !== ref_state(din)) begin n_fail++; $display("FAIL known_model got=%h exp=%h", dq[0], ref_state(din)); end
        do_consume(0, din);
    endtask

    task automatic test_all_63();
        logic [127:0] din = {16{8'h63}};
        int lat; bit bok;
        for (int k = 1; k < 3; k++) begin
            do_start(k, din, lat, bok);
            n_checks++; if (lat !== lat_exp[k]) begin n_fail++; $display("FAIL all63_latency inst=%0d got=%0d exp=%0d", k, lat, lat_exp[k]); end
            n_checks++; if (dq[k] !== 128'h0) begin n_fail++; $display("FAIL all63_data inst=%0d got=%h exp=0", k, dq[k]); end
            do_consume(k, din);
        end
    endtask

    task automatic test_random();
        logic [127:0] din;
        int lat; bit bok;
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 6; t++) begin
                din = rand128();
                do_start(k, din, lat, bok);
                n_checks++; if (lat !== lat_exp[k]) begin n_fail++; $display("FAIL rand_latency inst=%0d got=%0d exp=%0d", k, lat, lat_exp[k]); end
                n_checks++; if (!bok) begin n_fail++; $display("FAIL rand_busy inst=%0d got=0 exp=1", k); end
                n_checks++; if (dq[k] !== ref_state(din)) begin n_fail++; $display("FAIL rand_data inst=%0d got=%h exp=%h", k, dq[k], ref_state(din)); end
                do_consume(k, din);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] din = rand128();
        logic [127:0] exp_out;
        int lat; bit bok;
        exp_out = ref_state(din);
        do_start(0, din, lat, bok);
        iv[0] = 1'b1; di[0] = rand128();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++; if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", c, ov[0]); end
            n_checks++; if (dq[0] !== exp_out) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, dq[0], exp_out); end
            n_checks++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, ir[0]); end
        end
        iv[0] = 1'b0;
        do_consume(0, din);
        n_checks++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", ov[0], ir[0]); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got busy=%b exp=0", bz[0]); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a = rand128();
        logic [127:0] b = rand128();
        int n;
        @(negedge clk);
        ordy[0] = 1'b1; iv[0] = 1'b1; di[0] = a;
        @(posedge clk); @(negedge clk);
        di[0] = b;
        n = 0;
        while (!ov[0] && n < 100) begin @(posedge clk); n++; @(negedge clk); end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL b2b_lat_a got=%0d exp=4", n); end
        n_checks++; if (dq[0] !== ref_state(a)) begin n_fail++; $display("FAIL b2b_data_a got=%h exp=%h", dq[0], ref_state(a)); end
        $display("txn inst=0 in=%h out=%h", a, dq[0]);
        @(posedge clk); @(negedge clk);
        n_checks++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got ir=%b ov=%b exp ir=1 ov=0", ir[0], ov[0]); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (bz[0] !== 1'b1 || ir[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got busy=%b ir=%b exp busy=1 ir=0", bz[0], ir[0]); end
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 100) begin @(posedge clk); n++; @(negedge clk); end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL b2b_lat_b got=%0d exp=4", n); end
        n_checks++; if (dq[0] !== ref_state(b)) begin n_fail++; $display("FAIL b2b_data_b got=%h exp=%h", dq[0], ref_state(b)); end
        $display("txn inst=0 in=%h out=%h", b, dq[0]);
        @(posedge clk); @(negedge clk);
        ordy[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] din;
        int lat; bit bok; bit seen_ov = 1'b0;
        @(negedge clk);
        iv[0] = 1'b1; di[0] = rand128(); ordy[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", ov[0]); end
        n_checks++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bz[0]); end
        n_checks++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", ir[0]); end
        n_checks++; if (dq[0] !== 128'h0) begin n_fail++; $display("FAIL midrst_data got=%h exp=0", dq[0]); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (ov[0]) seen_ov = 1'b1;
        end
        n_checks++; if (seen_ov !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output got=1 exp=0"); end
        for (int i = 0; i < 16; i++) din[8*i +: 8] = 8'(i);
        do_start(0, din, lat, bok);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL midrst_fresh_lat got=%0d exp=4", lat); end
        n_checks++; if (dq[0] !== ref_state(din)) begin n_fail++; $display("FAIL midrst_fresh_data got=%h exp=%h", dq[0], ref_state(din)); end
        do_consume(0, din);
    endtask

    task automatic test_exhaustive();
        logic [127:0] din;
        logic [7:0] ob, ib;
        int lat; bit bok;
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) din[8*i +: 8] = 8'(16*j + i);
            do_start(0, din, lat, bok);
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL exh_latency state=%0d got=%0d exp=4", j, lat); end
            for (int i = 0; i < 16; i++) begin
                ib = din[8*i +: 8];
                ob = dq[0][8*i +: 8];
                n_checks++; if (ob !== inv_tab[ib]) begin n_fail++; $display("FAIL exh_byte in=%h got=%h exp=%h", ib, ob, inv_tab[ib]); end
                n_checks++; if (fwd_tab[ob] !== ib) begin n_fail++; $display("FAIL exh_roundtrip out=%h got=%h exp=%h", ob, fwd_tab[ob], ib); end
            end
            do_consume(0, din);
        end
    endtask

    initial begin
        logic [7:0] s;
        rst = 1'b1; iv = '0; ordy = '0; di = '0;
        for (int x = 0; x < 256; x++) begin
            s = fwd_sbox(8'(x));
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
        test_reset();
        test_known_vector();
        test_all_63();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
